// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b opcode, condition-code and branch-resolution types shared by the pipeline.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_jsr  = 4'b0100,
    op_jmp  = 4'b1100,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef logic [2:0] lc3b_nzp;

  typedef struct packed {
    logic        taken;
    logic        mispredict;
    logic [15:0] target;
  } br_resolve_t;

  function automatic lc3b_nzp gen_nzp(input logic [15:0] value);
    return {value[15], value == 16'h0000, !value[15] && (value != 16'h0000)};
  endfunction

endpackage

// File: rtl/bht_counters.sv
// rtl/bht_counters.sv - Branch history table of saturating counters: combinational read, registered train.
module bht_counters #(
  parameter int BHT_ENTRIES = 16,
  parameter int CTR_WIDTH   = 2,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             train_en,
  input  logic [IDX_W-1:0] train_idx,
  input  logic             train_taken
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);

  logic [CTR_WIDTH-1:0] ctr [BHT_ENTRIES];

  // A train and a read of the same entry in one cycle returns the pre-edge value.
  assign rd_taken = ctr[rd_idx][CTR_WIDTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (train_en) begin
      if (train_taken) begin
        if (ctr[train_idx] != CTR_MAX) ctr[train_idx] <= ctr[train_idx] + CTR_ONE;
      end else begin
        if (ctr[train_idx] != '0) ctr[train_idx] <= ctr[train_idx] - CTR_ONE;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - Writeback-stage resolver for BR/JMP/JSR/TRAP with nzp register and BHT training.
module branch_resolve_unit
  import lc3b_types::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int CTR_WIDTH   = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_in,
  input  logic [15:0]          ir_in,
  input  logic [15:0]          pc_in,
  input  logic [15:0]          base_in,
  input  logic                 cc_load,
  input  logic [15:0]          cc_value_in,
  input  logic                 pred_taken_in,
  input  logic [15:0]          lookup_pc,
  output logic                 lookup_taken,
  output logic                 redirect_valid,
  output logic [15:0]          redirect_pc,
  output logic                 redirect_is_trap,
  output logic                 squash,
  output logic [2:0]           cc_out,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  lc3b_nzp           cc;
  br_resolve_t       br;
  logic              is_br;
  logic [15:0]       br_pc;
  logic              nxt_valid;
  logic [15:0]       nxt_pc;
  logic              nxt_trap;
  logic              unused_pc_bits;

  // pc_in is already PC+2, so the branch's own address is one word back.
  assign br_pc = pc_in - 16'd2;
  assign is_br = (ir_in[15:12] == op_br) && (ir_in != 16'h0000);
  assign unused_pc_bits = ^{lookup_pc[15:IDX_W+1], lookup_pc[0], br_pc[15:IDX_W+1], br_pc[0]};

  always_comb begin
    br.taken      = |(ir_in[11:9] & cc);
    br.mispredict = br.taken != pred_taken_in;
    br.target     = pc_in + {{6{ir_in[8]}}, ir_in[8:0], 1'b0};
  end

  always_comb begin
    nxt_valid = 1'b0;
    nxt_pc    = redirect_pc;
    nxt_trap  = 1'b0;
    if (valid_in) begin
      case (ir_in[15:12])
        op_br: begin
          if (is_br && br.mispredict) begin
            nxt_valid = 1'b1;
            nxt_pc    = br.taken ? br.target : pc_in;
          end
        end
        op_jmp: begin
          nxt_valid = 1'b1;
          nxt_pc    = base_in;
        end
        op_jsr: begin
          nxt_valid = 1'b1;
          nxt_pc    = ir_in[11] ? pc_in + {{4{ir_in[10]}}, ir_in[10:0], 1'b0} : base_in;
        end
        op_trap: begin
          nxt_valid = 1'b1;
          nxt_pc    = {7'b0, ir_in[7:0], 1'b0};
          nxt_trap  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc               <= 3'b010;
      redirect_valid   <= 1'b0;
      redirect_pc      <= 16'h0000;
      redirect_is_trap <= 1'b0;
      mispredict_count <= '0;
    end else begin
      redirect_valid   <= nxt_valid;
      redirect_pc      <= nxt_pc;
      redirect_is_trap <= nxt_trap;
      if (valid_in && cc_load && !is_br) cc <= gen_nzp(cc_value_in);
      if (valid_in && is_br && br.mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

  assign squash = redirect_valid;
  assign cc_out = cc;

  bht_counters #(
    .BHT_ENTRIES(BHT_ENTRIES),
    .CTR_WIDTH  (CTR_WIDTH)
  ) u_bht (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_idx     (lookup_pc[IDX_W:1]),
    .rd_taken   (lookup_taken),
    .train_en   (valid_in && is_br),
    .train_idx  (br_pc[IDX_W:1]),
    .train_taken(br.taken)
  );

endmodule
